// File: rtl/count_seq_mon_pkg.sv
// Shared types and helpers for the count sequence monitor: state encoding,
// default widths and the modular next-value calculation.
package count_seq_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ERR_W = 8;

   typedef struct packed {
      logic [31:0] value;
      logic        wrap;
   } exp_t;

   // One extra bit of headroom keeps prev+step from overflowing before the wrap test.
   function automatic exp_t next_expected(input logic [31:0] prev,
                                          input logic [31:0] step,
                                          input logic [31:0] max_val);
      logic [32:0] sum;
      exp_t        r;
      sum = {1'b0, prev} + {1'b0, step};
      if (sum > {1'b0, max_val}) begin
         r.value = 32'(sum - ({1'b0, max_val} + 33'd1));
         r.wrap  = 1'b1;
      end else begin
         r.value = sum[31:0];
         r.wrap  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/count_sequence_monitor_sat_counter.sv
// Event counter that sticks at all-ones; synchronous clear has priority over inc.
// Count is registered, so it updates on the edge that captures the event.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/count_sequence_monitor.sv
// Checks a sampled counter advances by STEP modulo MAX_VAL+1; locks after LOCK_CNT good steps.
// All outputs are registered one cycle after the en sample; no backpressure, every en is consumed.
module count_sequence_monitor
   import count_seq_mon_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int STEP     = 1,
   parameter int MAX_VAL  = 15,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] count_in,
   input  logic [WIDTH-1:0] target,
   output logic             locked,
   output logic             seq_err,
   output logic             wrap_pulse,
   output logic             hit,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] wrap_cnt,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [3:0]       good_q, good_d;
   logic             locked_q, locked_d;
   logic             seq_err_q, seq_err_d;
   logic             wrap_q, wrap_d;
   logic             hit_q, hit_d;

   exp_t             exp_r;
   logic             step_ok;
   logic [4:0]       good_inc;

   // Out-of-range count_in can never equal exp, which is always <= MAX_VAL.
   always_comb begin
      exp_r    = next_expected(32'(prev_q), 32'(STEP), 32'(MAX_VAL));
      step_ok  = (32'(count_in) == exp_r.value);
      good_inc = {1'b0, good_q} + 5'd1;
   end

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      good_d    = good_q;
      locked_d  = locked_q;
      seq_err_d = 1'b0;
      wrap_d    = 1'b0;
      hit_d     = 1'b0;
      if (clr) begin
         state_d  = ST_IDLE;
         prev_d   = '0;
         good_d   = '0;
         locked_d = 1'b0;
      end else if (en) begin
         prev_d = count_in;
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SEARCH;
               good_d  = '0;
            end
            ST_SEARCH: begin
               if (step_ok) begin
                  good_d = good_inc[3:0];
                  if (good_inc == 5'(LOCK_CNT)) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  good_d = '0;
               end
            end
            ST_LOCKED: begin
               if (step_ok) begin
                  wrap_d = exp_r.wrap;
                  hit_d  = (count_in == target);
               end else begin
                  seq_err_d = 1'b1;
                  state_d   = ST_SEARCH;
                  good_d    = '0;
                  locked_d  = 1'b0;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               good_d   = '0;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         prev_q    <= '0;
         good_q    <= '0;
         locked_q  <= 1'b0;
         seq_err_q <= 1'b0;
         wrap_q    <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         good_q    <= good_d;
         locked_q  <= locked_d;
         seq_err_q <= seq_err_d;
         wrap_q    <= wrap_d;
         hit_q     <= hit_d;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (clr),
      .inc   (seq_err_d),
      .cnt   (err_cnt)
   );

   sat_counter #(.W(ERR_W)) u_wrap_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (clr),
      .inc   (wrap_d),
      .cnt   (wrap_cnt)
   );

   assign locked     = locked_q;
   assign seq_err    = seq_err_q;
   assign wrap_pulse = wrap_q;
   assign hit        = hit_q;
   assign state      = state_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Bench for count_sequence_monitor: a default instance and a MAX_VAL=9 / ERR_W=2 instance
// share stimulus; both are checked every cycle against a modular-arithmetic reference model.
module tb_count_sequence_monitor;

   localparam int STEP = 1;
   localparam int LOCK = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic [3:0] target = 4'd6;

   logic       lk0, se0, wp0, hi0;
   logic [7:0] ec0, wc0;
   logic [1:0] st0;
   logic       lk1, se1, wp1, hi1;
   logic [1:0] ec1, wc1;
   logic [1:0] st1;

   int checks = 0;
   int errors = 0;

   int p_max[2] = '{15, 9};
   int p_sat[2] = '{255, 3};

   // Reference model: phase 0/1/2 = idle/search/locked.
   int m_phase[2], m_prev[2], m_good[2];
   int m_err[2], m_wrap[2], m_hit[2], m_errc[2], m_wrapc[2];

   always #5 clk = ~clk;

   count_sequence_monitor u_dut0 (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .count_in(count_in), .target(target),
      .locked(lk0), .seq_err(se0), .wrap_pulse(wp0), .hit(hi0),
      .err_cnt(ec0), .wrap_cnt(wc0), .state(st0)
   );

   count_sequence_monitor #(.MAX_VAL(9), .ERR_W(2)) u_dut1 (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .count_in(count_in), .target(target),
      .locked(lk1), .seq_err(se1), .wrap_pulse(wp1), .hit(hi1),
      .err_cnt(ec1), .wrap_cnt(wc1), .state(st1)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = 0; m_prev[i] = 0; m_good[i] = 0;
         m_err[i] = 0; m_wrap[i] = 0; m_hit[i] = 0; m_errc[i] = 0; m_wrapc[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit e, input bit c, input int v, input int tgt);
      int expv;
      bit wrapped;
      bit ok;
      m_err[i] = 0; m_wrap[i] = 0; m_hit[i] = 0;
      if (c) begin
         m_phase[i] = 0; m_prev[i] = 0; m_good[i] = 0; m_errc[i] = 0; m_wrapc[i] = 0;
      end else if (e) begin
         expv    = (m_prev[i] + STEP) % (p_max[i] + 1);
         wrapped = (m_prev[i] + STEP) > p_max[i];
         ok      = (v == expv);
         if (m_phase[i] == 0) begin
            m_phase[i] = 1; m_good[i] = 0;
         end else if (m_phase[i] == 1) begin
            if (ok) begin
               m_good[i]++;
               if (m_good[i] == LOCK) m_phase[i] = 2;
            end else begin
               m_good[i] = 0;
            end
         end else begin
            if (ok) begin
               if (wrapped) begin
                  m_wrap[i] = 1;
                  if (m_wrapc[i] < p_sat[i]) m_wrapc[i]++;
               end
               m_hit[i] = (v == tgt) ? 1 : 0;
            end else begin
               m_err[i] = 1;
               if (m_errc[i] < p_sat[i]) m_errc[i]++;
               m_phase[i] = 1; m_good[i] = 0;
            end
         end
         m_prev[i] = v;
      end
   endtask

   task automatic check_dut(input int i, input string n, input logic lk, input logic se,
                            input logic wp, input logic hi, input logic [7:0] ec,
                            input logic [7:0] wc, input logic [1:0] st);
      chk({n, ".locked"},   32'(lk), (m_phase[i] == 2) ? 32'd1 : 32'd0);
      chk({n, ".state"},    32'(st), m_phase[i]);
      chk({n, ".seq_err"},  32'(se), m_err[i]);
      chk({n, ".wrap"},     32'(wp), m_wrap[i]);
      chk({n, ".hit"},      32'(hi), m_hit[i]);
      chk({n, ".err_cnt"},  32'(ec), m_errc[i]);
      chk({n, ".wrap_cnt"}, 32'(wc), m_wrapc[i]);
   endtask

   task automatic check_all();
      check_dut(0, "d0", lk0, se0, wp0, hi0, ec0, wc0, st0);
      check_dut(1, "d1", lk1, se1, wp1, hi1, {6'd0, ec1}, {6'd0, wc1}, st1);
   endtask

   // Drive at the falling edge, let the rising edge sample, compare at the next falling edge.
   task automatic cycle(input bit e, input bit c, input int v);
      en = e; clr = c; count_in = 4'(v);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i, e, c, v, int'(target));
      @(negedge clk);
      check_all();
   endtask

   task automatic feed(input int v);
      cycle(1'b1, 1'b0, v);
   endtask

   int err_seq[21] = '{0,1,2,3,5,6,7,8,0,1,2,3,5,6,7,8,0,1,2,3,5};
   int last_v;
   bit re, rc;
   int rv;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b1;

      // Lock on 0,1,2,3
      feed(0); chk("lock.s0", 32'(lk0), 0);
      feed(1); chk("lock.s1", 32'(lk0), 0);
      feed(2); chk("lock.s2", 32'(lk0), 0);
      feed(3); chk("lock.s3", 32'(lk0), 1); chk("lock.state", 32'(st0), 2);

      // Hit on target 6 while locked
      feed(4); chk("hit.s4", 32'(hi0), 0);
      feed(5); chk("hit.s5", 32'(hi0), 0);
      feed(6); chk("hit.s6", 32'(hi0), 1);
      feed(7); chk("hit.after", 32'(hi0), 0);

      // Wrap 14,15,0
      for (int v = 8; v <= 13; v++) feed(v);
      feed(14); chk("wrap.s14", 32'(wp0), 0);
      feed(15); chk("wrap.s15", 32'(wp0), 0);
      feed(0);  chk("wrap.s0", 32'(wp0), 1); chk("wrap.cnt", 32'(wc0), 1);
      chk("wrap.noerr", 32'(se0), 0);
      feed(1);  chk("wrap.once", 32'(wp0), 0);

      // Error at 5 -> 7, then relock on 8,9,10
      feed(2); feed(3); feed(4); feed(5);
      feed(7);
      chk("err.pulse", 32'(se0), 1); chk("err.cnt", 32'(ec0), 1);
      chk("err.locked", 32'(lk0), 0); chk("err.state", 32'(st0), 1);
      feed(8); feed(9); chk("err.s9", 32'(lk0), 0);
      feed(10); chk("err.relock", 32'(lk0), 1);

      // A correct 6 while searching must not hit
      feed(3); chk("search.err", 32'(ec0), 2);
      feed(4); feed(5);
      feed(6); chk("search.hit", 32'(hi0), 0); chk("search.lock", 32'(lk0), 1);

      // Gap of five idle cycles is not an error
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, int'($urandom_range(0, 15)));
         chk("gap.seq_err", 32'(se0), 0);
         chk("gap.locked", 32'(lk0), 1);
      end
      feed(7); chk("gap.resume", 32'(se0), 0); chk("gap.locked2", 32'(lk0), 1);

      // Out-of-range 15 on the MAX_VAL=9 instance
      feed(0); feed(1); feed(2); feed(3);
      chk("oor.locked", 32'(lk1), 1);
      feed(15); chk("oor.seq_err", 32'(se1), 1);

      // Asynchronous reset between edges while locked
      feed(0); feed(1); feed(2); feed(3);
      chk("arst.pre0", 32'(lk0), 1); chk("arst.pre1", 32'(lk1), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst.locked", 32'(lk0), 0);  chk("arst.state", 32'(st0), 0);
      chk("arst.err_cnt", 32'(ec0), 0); chk("arst.wrap_cnt", 32'(wc0), 0);
      chk("arst.seq_err", 32'(se0), 0); chk("arst.hit", 32'(hi0), 0);
      chk("arst.wrap", 32'(wp0), 0);    chk("arst.d1_locked", 32'(lk1), 0);
      chk("arst.d1_err_cnt", 32'(ec1), 0);
      model_reset();
      @(negedge clk);
      check_all();
      reset = 1'b1;

      // clr beats a simultaneous mismatching sample
      feed(0); feed(1); feed(2); feed(3); feed(9);
      chk("clr.pre_err", 32'(ec0), 1);
      cycle(1'b1, 1'b1, 12);
      chk("clr.state", 32'(st0), 0); chk("clr.err_cnt", 32'(ec0), 0);
      chk("clr.seq_err", 32'(se0), 0); chk("clr.locked", 32'(lk0), 0);

      // Five errors: 2-bit counter saturates at 3, 8-bit one reaches 5
      foreach (err_seq[k]) feed(err_seq[k]);
      chk("sat.d1_err_cnt", 32'(ec1), 3); chk("sat.d1_pulse", 32'(se1), 1);
      chk("sat.d0_err_cnt", 32'(ec0), 5);

      // Random mostly-correct traffic with gaps, clears and target changes
      last_v = 5;
      for (int n = 0; n < 400; n++) begin
         re = ($urandom_range(0, 9) < 8);
         rc = ($urandom_range(0, 49) == 0);
         rv = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 15)) : (last_v + 1) % 16;
         if ($urandom_range(0, 19) == 0) target = 4'($urandom_range(0, 15));
         if (re) last_v = rv;
         cycle(re, rc, rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_sequence_monitor.md
Name: count_sequence_monitor

Overview:
- Downstream consumer of the 4-bit sequence counter output.
- Samples the counter value and checks that it advances by STEP modulo (MAX_VAL+1).
- Locks after LOCK_CNT consecutive correct steps, then flags sequence errors, wraps and target hits.
- Keeps saturating error and wrap counts for status readout and bench self-checking.

Parameters:
- WIDTH, 4, width of the monitored count.
- STEP, 1, expected increment per sample.
- MAX_VAL, 15, highest legal count; the value after MAX_VAL wraps modulo MAX_VAL+1.
- LOCK_CNT, 3, consecutive correct steps needed to reach LOCKED (range 1..15).
- ERR_W, 8, width of the err_cnt and wrap_cnt counters.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- en, input, 1, count_in is sampled on this cycle.
- clr, input, 1, synchronous clear of state and counters.
- count_in, input, WIDTH, counter value under check.
- target, input, WIDTH, value that raises hit.
- locked, output, 1, high while in LOCKED.
- seq_err, output, 1, one-cycle pulse on a mismatch while LOCKED.
- wrap_pulse, output, 1, one-cycle pulse on a correct wrap while LOCKED.
- hit, output, 1, one-cycle pulse when count_in==target on a correct step while LOCKED.
- err_cnt, output, ERR_W, saturating count of seq_err events.
- wrap_cnt, output, ERR_W, saturating count of wrap_pulse events.
- state, output, 2, FSM state: IDLE=0, SEARCH=1, LOCKED=2.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prev=0; good=0.
  - All outputs 0, taking effect immediately without a clock edge.
- All outputs are registered and reflect a sample one cycle after the en cycle.
- Expected value:
  - exp = prev+STEP, computed in WIDTH+1 bits.
  - If the sum exceeds MAX_VAL, exp = sum-(MAX_VAL+1) and the step is a wrap.
- A step is correct when count_in==exp. Any count_in>MAX_VAL is a mismatch.
- en=0:
  - State, prev, good and counters hold.
  - seq_err, wrap_pulse and hit are 0.
  - A gap between samples is never an error.
- clr=1 returns to the IDLE state: counters, good and all pulses go to 0. clr wins over a simultaneous en.
- On every en cycle, prev<=count_in.
- IDLE, on en: go to SEARCH with good=0. No checking is done on the first sample.
- SEARCH, on en:
  - Correct step: good++. If good+1==LOCK_CNT, go to LOCKED and set locked=1.
  - Mismatch: good=0, stay in SEARCH. No seq_err, no err_cnt change.
  - Wraps in SEARCH raise no wrap_pulse.
- LOCKED, on en:
  - Correct step: stay. If it was a wrap, wrap_pulse=1 and wrap_cnt++. If count_in==target, hit=1.
  - Mismatch: seq_err=1, err_cnt++, go to SEARCH with good=0, locked=0.
- err_cnt and wrap_cnt saturate at 2^ERR_W-1. The event pulses still fire at saturation.
- A non-default STEP that does not divide MAX_VAL+1 is legal; modular arithmetic is applied as above.

Decomposition:
- Package count_seq_mon_pkg holds:
  - The state encoding constants (IDLE, SEARCH, LOCKED).
  - The default WIDTH and ERR_W constants.
  - A function next_expected(prev, STEP, MAX_VAL) that returns exp and the wrap flag.
- One sub-module, sat_counter (parameter W; inputs clr and inc; output cnt), is instantiated twice, once for err_cnt and once for wrap_cnt.

Test Plan:
1. Lock: after reset, feed 0,1,2,3 with en every cycle -> locked=1 and state=2 one cycle after the sample of 3. locked stays 0 after samples 0..2.
2. Wrap: while locked, feed 14,15,0 -> wrap_pulse high for exactly one cycle after 0 is sampled, wrap_cnt=1, no seq_err.
3. Error: while locked at 5, feed 7 -> seq_err pulse, err_cnt=1, locked=0, state=1. Then feed 8,9,10 -> relocked after 10.
4. Hit: target=6, locked, feed 4,5,6 -> hit one cycle after 6 only. A SEARCH-state 6 gives hit=0.
5. Gaps and out-of-range input:
   - Locked at 3, hold en=0 for 5 cycles, then feed 4 -> no seq_err, still locked.
   - Feed 15 with MAX_VAL=9 -> seq_err.
6. Reset and clear:
   - Drive reset=0 mid-LOCKED between clock edges -> all outputs 0 at once.
   - clr=1 together with en and a mismatching count_in -> state=0, err_cnt=0, seq_err=0.
   - With ERR_W=2, force 5 errors -> err_cnt holds at 3.
